operand_fetch: RTL



---
 rtl/operand_fetch.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Operand-fetch stage in front of an NREG x DW register file with a one-cycle
// read latency. A decoded instruction is accepted over a valid/ready handshake
// and waits in HAZARD while either source register has a pending write. It
// then drives the read selects (READ) and captures the returned operands
// (CAPTURE). Writebacks seen in those two cycles are forwarded. Finally it
// holds the operand bundle (OUT) until the execute stage takes it.
//
// The stage also owns the register-file write port, which is a straight
// pass-through of the writeback bus. It keeps a scoreboard of registers that
// have a write in flight.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             instruction handshake
//   in_rs1, in_rs2, in_rd           source / destination selects
//   in_op, in_has_dest              opcode, destination-write flag
//   out_valid / out_ready           operand bundle handshake
//   out_op, out_rd, out_has_dest    registered instruction fields
//   out_a, out_b                    operand values for rs1, rs2
//   rf_rd_sel_1/2, rf_rd_data_1/2   register file read ports
//   wb_valid, wb_sel, wb_data       writeback from execute
//   rf_wr_en, rf_wr_sel, rf_wr_data register file write port
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter  int NREG = 8,
    parameter  int DW   = 16,
    localparam int SW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_rs1,
    input  logic [SW-1:0] in_rs2,
    input  logic [SW-1:0] in_rd,
    input  logic [3:0]    in_op,
    input  logic          in_has_dest,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_op,
    output logic [SW-1:0] out_rd,
    output logic          out_has_dest,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,

    output logic [SW-1:0] rf_rd_sel_1,
    output logic [SW-1:0] rf_rd_sel_2,
    input  logic [DW-1:0] rf_rd_data_1,
    input  logic [DW-1:0] rf_rd_data_2,

    input  logic          wb_valid,
    input  logic [SW-1:0] wb_sel,
    input  logic [DW-1:0] wb_data,

    output logic          rf_wr_en,
    output logic [SW-1:0] rf_wr_sel,
    output logic [DW-1:0] rf_wr_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HAZARD,
        ST_READ,
        ST_CAPTURE,
        ST_OUT
    } state_t;

    state_t          state_q, state_next;

    logic [SW-1:0]   rs1_q, rs2_q, rd_q;
    logic [3:0]      op_q;
    logic            has_dest_q;
    logic [SW-1:0]   sel_1_q, sel_2_q;
    logic [DW-1:0]   a_q, b_q;
    logic [NREG-1:0] busy_q, busy_next;

    // Writeback seen during READ, held so it can still win in CAPTURE when
    // no newer writeback to the same register arrives.
    logic            fwd_1_valid_q, fwd_2_valid_q;
    logic [DW-1:0]   fwd_1_data_q, fwd_2_data_q;

    logic            accept;
    logic            out_fire;
    logic            hazard;
    logic            wb_hit_1, wb_hit_2;

    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign out_fire = (state_q == ST_OUT) && out_ready;
    assign hazard   = busy_q[rs1_q] | busy_q[rs2_q];
    assign wb_hit_1 = wb_valid && (wb_sel == rs1_q);
    assign wb_hit_2 = wb_valid && (wb_sel == rs2_q);

    // Next-state logic.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:    if (in_valid)  state_next = ST_HAZARD;
            ST_HAZARD:  if (!hazard)   state_next = ST_READ;
            ST_READ:                   state_next = ST_CAPTURE;
            ST_CAPTURE:                state_next = ST_OUT;
            ST_OUT:     if (out_ready) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // Scoreboard update: the clear is applied first so a set of the same
    // register in the same cycle overrides it.
    always_comb begin
        busy_next = busy_q;
        if (wb_valid)
            busy_next[wb_sel] = 1'b0;
        if (out_fire && has_dest_q)
            busy_next[rd_q] = 1'b1;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            op_q          <= '0;
            has_dest_q    <= 1'b0;
            sel_1_q       <= '0;
            sel_2_q       <= '0;
            fwd_1_valid_q <= 1'b0;
            fwd_2_valid_q <= 1'b0;
            fwd_1_data_q  <= '0;
            fwd_2_data_q  <= '0;
            a_q           <= '0;
            b_q           <= '0;
            busy_q        <= '0;
        end else begin
            state_q <= state_next;
            busy_q  <= busy_next;

            if (accept) begin
                rs1_q      <= in_rs1;
                rs2_q      <= in_rs2;
                rd_q       <= in_rd;
                op_q       <= in_op;
                has_dest_q <= in_has_dest;
            end

            // Selects are registered on the HAZARD->READ edge so they are
            // presented throughout READ and then hold until the next read.
            if ((state_q == ST_HAZARD) && !hazard) begin
                sel_1_q <= rs1_q;
                sel_2_q <= rs2_q;
            end

            if (state_q == ST_READ) begin
                fwd_1_valid_q <= wb_hit_1;
                fwd_2_valid_q <= wb_hit_2;
                fwd_1_data_q  <= wb_data;
                fwd_2_data_q  <= wb_data;
            end

            // Priority: writeback in CAPTURE, then writeback in READ, then the
            // register file (which cannot yet reflect a READ-cycle write).
            if (state_q == ST_CAPTURE) begin
                a_q <= wb_hit_1      ? wb_data      :
                       fwd_1_valid_q ? fwd_1_data_q : rf_rd_data_1;
                b_q <= wb_hit_2      ? wb_data      :
                       fwd_2_valid_q ? fwd_2_data_q : rf_rd_data_2;
            end
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_OUT);
    assign out_op       = op_q;
    assign out_rd       = rd_q;
    assign out_has_dest = has_dest_q;
    assign out_a        = a_q;
    assign out_b        = b_q;
    assign rf_rd_sel_1  = sel_1_q;
    assign rf_rd_sel_2  = sel_2_q;

    assign rf_wr_en     = wb_valid;
    assign rf_wr_sel    = wb_sel;
    assign rf_wr_data   = wb_data;

endmodule
